// File: rtl/forwarding_hazard_unit_if.sv
// forwarding_hazard_unit_if: ID instruction in, stall out, EX/DM control bundle out.
interface forwarding_hazard_unit_if #(
   parameter int IW = 32,
   parameter int AW = 5,
   parameter int SW = 2
);
   logic [IW-1:0] ins;
   logic          ins_valid;
   logic          stall;
   logic [5:0]    op_dec;
   logic [15:0]   imm;
   logic          imm_sel;
   logic [SW-1:0] mux_sel_A;
   logic [SW-1:0] mux_sel_B;
   logic          mem_en_ex;
   logic          mem_rw_ex;
   logic          mem_mux_sel_dm;
   logic [AW-1:0] RW_dm;
   modport master (
      output ins, ins_valid,
      input  stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
             mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm
   );
   modport slave (
      input  ins, ins_valid,
      output stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
             mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm
   );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: ID decode, DEPTH-deep destination scoreboard, forwarding selects and load-use stall.
// Define HAZARD_STATS_EN to add saturating stall_cnt/fwd_cnt outputs.
module forwarding_hazard_unit #(
   parameter int         IW       = 32,
   parameter int         AW       = 5,
   parameter int         DEPTH    = 3,
   parameter int         SW       = 2,
   parameter int         LOAD_LAT = 2,
   parameter logic [5:0] LOAD_OP  = 6'b010100,
   parameter logic [5:0] STORE_OP = 6'b010101,
   parameter logic [5:0] NOP_OP   = 6'b111111
) (
   input logic clk,
   input logic reset,
   forwarding_hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] fwd_cnt
`endif
);
   logic [5:0]    op;
   logic [AW-1:0] rw, ra, rb, src_b;
   logic          is_ld, is_st, imm_cls, use_b, bubble, stall;
   logic [SW-1:0] sel_a, sel_b;
   logic          ld_a, ld_b;
   logic [AW-1:0] sb_dst [1:DEPTH];
   logic [DEPTH:1] sb_wr, sb_ld;
   logic          ex_ld;
   logic [AW-1:0] ex_dst;

   assign op      = bus.ins[31:26];
   assign rw      = bus.ins[21 +: AW];
   assign ra      = bus.ins[16 +: AW];
   assign rb      = bus.ins[11 +: AW];
   assign is_ld   = op == LOAD_OP;
   assign is_st   = op == STORE_OP;
   assign imm_cls = is_ld || is_st || op[4];
   // stores read their data register through the B path
   assign use_b   = !imm_cls || is_st;
   assign src_b   = is_st ? rw : rb;

   // descending scan so the youngest matching producer is the last one written
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (ra != '0 && sb_wr[k] && sb_dst[k] == ra) begin
            sel_a = SW'(k);
            ld_a  = ld_a || (k < LOAD_LAT && sb_ld[k]);
         end
         if (src_b != '0 && sb_wr[k] && sb_dst[k] == src_b) begin
            sel_b = SW'(k);
            ld_b  = ld_b || (k < LOAD_LAT && sb_ld[k]);
         end
      end
   end

   assign stall     = bus.ins_valid && (ld_a || (use_b && ld_b));
   assign bus.stall = stall;
   assign bubble    = !bus.ins_valid || stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++) sb_dst[k] <= '0;
         sb_wr              <= '0;
         sb_ld              <= '0;
         ex_ld              <= 1'b0;
         ex_dst             <= '0;
         bus.op_dec         <= '0;
         bus.imm            <= '0;
         bus.imm_sel        <= 1'b0;
         bus.mux_sel_A      <= '0;
         bus.mux_sel_B      <= '0;
         bus.mem_en_ex      <= 1'b0;
         bus.mem_rw_ex      <= 1'b0;
         bus.mem_mux_sel_dm <= 1'b0;
         bus.RW_dm          <= '0;
      end else begin
         for (int k = DEPTH; k > 1; k--) begin
            sb_dst[k] <= sb_dst[k-1];
            sb_wr[k]  <= sb_wr[k-1];
            sb_ld[k]  <= sb_ld[k-1];
         end
         sb_dst[1]          <= (bubble || is_st) ? '0 : rw;
         sb_wr[1]           <= !bubble && !is_st;
         sb_ld[1]           <= !bubble && is_ld;
         ex_ld              <= !bubble && is_ld;
         ex_dst             <= (bubble || is_st) ? '0 : rw;
         bus.op_dec         <= bubble ? NOP_OP : op;
         bus.imm            <= bubble ? '0 : bus.ins[15:0];
         bus.imm_sel        <= !bubble && imm_cls;
         bus.mux_sel_A      <= bubble ? '0 : sel_a;
         bus.mux_sel_B      <= (bubble || !use_b) ? '0 : sel_b;
         bus.mem_en_ex      <= !bubble && (is_ld || is_st);
         bus.mem_rw_ex      <= !bubble && is_st;
         bus.mem_mux_sel_dm <= ex_ld;
         bus.RW_dm          <= ex_dst;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
         if ((bus.mux_sel_A != '0 || bus.mux_sel_B != '0) && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Parametrised decode-side hazard block for the MIPS_16bit pipeline.
- Decodes the instruction in ID and tracks in-flight destination registers over DEPTH downstream stages.
- Produces registered operand-forwarding selects, memory controls and immediate selection for EX and DM.
- Detects load-use hazards, raises `stall` and inserts bubbles; generalises the fixed 3-stage forwarding decoder to configurable depth and load latency.

Parameters:
- IW, 32, instruction width.
- AW, 5, register address width; register 0 is hardwired zero.
- DEPTH, 3, number of older in-flight instructions tracked and forwardable (1..7).
- SW, 2, mux_sel width; must satisfy 2^SW > DEPTH.
- LOAD_LAT, 2, age at which load data becomes forwardable (1..DEPTH).
- LOAD_OP, 6'b010100, load opcode.
- STORE_OP, 6'b010101, store opcode.
- NOP_OP, 6'b111111, opcode driven on bubbles.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ins  in  IW  instruction in ID.
  - Fields: op=[31:26], RW=[25:21], RA=[20:16], RB=[15:11], imm=[15:0].
- ins_valid  in  1  ins is a real instruction; 0 means bubble.
- stall  out  1  combinational; upstream must hold PC/IF-ID and re-present ins.
- op_dec  out  6  EX opcode.
- imm  out  16  EX immediate.
- imm_sel  out  1  EX B operand from imm.
- mux_sel_A  out  SW  EX A source: 0 = register file, k = result of instruction k cycles older.
- mux_sel_B  out  SW  EX B source (store: store-data source), same encoding as mux_sel_A.
- mem_en_ex  out  1  data memory enable for the instruction in EX.
- mem_rw_ex  out  1  1 = write (store), 0 = read.
- mem_mux_sel_dm  out  1  writeback takes memory data (load in DM).
- RW_dm  out  AW  writeback destination in DM; 0 when there is no writeback.

Behaviour:
- Decode classes:
  - op==LOAD_OP: writes RW, reads RA, imm_sel=1.
  - op==STORE_OP: reads RA and RW (store data), imm_sel=1, no writeback.
  - other op with op[4]=1: imm-ALU; writes RW, reads RA, imm_sel=1.
  - otherwise reg-ALU; writes RW, reads RA and RB.
- Scoreboard: DEPTH entries {dst, wr, ld}; entry 1 is the youngest older instruction. Each edge shifts entry k to k+1 and loads entry 1 from ID; the oldest entry is dropped.
  - Entry 1 gets wr=0 when ins_valid=0, stall=1, or the decoded instruction has no writeback.
  - dst is stored as 0 when wr=0.
- Forward match: source s matches entry k when s!=0, wr[k]=1 and dst[k]==s. Smallest k wins (youngest producer). No match gives 0.
- Load-use: stall=1 when ins_valid=1 and some used source matches an entry k<LOAD_LAT with ld[k]=1.
  - Re-evaluated every cycle, so a multi-cycle stall arises naturally (LOAD_LAT=2 with the load at k=1 gives exactly 1 stall cycle).
- Registered EX outputs (1-cycle latency from ID):
  - op_dec, imm, imm_sel, mux_sel_A/B, mem_en_ex, mem_rw_ex.
  - On bubble (ins_valid=0 or stall=1): op_dec=NOP_OP, imm=0, imm_sel=0, selects=0, mem_en_ex=0, mem_rw_ex=0.
  - Unused source gives select 0.
- DM outputs (2-cycle latency): mem_mux_sel_dm=1 for a load; RW_dm=dst for a writeback instruction, else 0.
- Reset (async, any time, including mid-stall): all outputs 0, all scoreboard wr/ld=0.
  - op_dec is 0 during reset; bubbles after reset use NOP_OP.
  - stall=0 on the first cycle after reset.
- RW=0 destination: never forwarded and never stalls.
- Simultaneous matches in several stages: youngest wins.

Optional Feature:
- HAZARD_STATS_EN defined: adds outputs `stall_cnt[15:0]` and `fwd_cnt[15:0]`.
  - Both are saturating at 16'hFFFF and reset to 0.
  - stall_cnt increments on each cycle with stall=1.
  - fwd_cnt increments on each registered cycle with mux_sel_A!=0 or mux_sel_B!=0; it increments by 1 even if both are non-zero.
- HAZARD_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset pulse mid-stream, then ins_valid=0 -> all outputs 0 during reset; op_dec=6'b111111 and stall=0 afterwards.
- Reg-ALU R1<=R2,R3, then reg-ALU reading RA=1 next cycle -> second instruction's mux_sel_A=1 one cycle later, mux_sel_B=0.
- Producer of R1, one unrelated instruction, then a reader of R1 -> mux_sel_A=2. With DEPTH=3, a reader three cycles later gets 3; four cycles later gets 0.
- LOAD_OP into R4, then reg-ALU reading RB=4 -> stall=1 for exactly 1 cycle and bubble op_dec=NOP_OP. Re-presented instruction gets mux_sel_B=2. Load's mem_en_ex=1, mem_rw_ex=0, then mem_mux_sel_dm=1 with RW_dm=4.
- STORE_OP with RW=5 right after a writer of R5 -> mux_sel_B=1, imm_sel=1, mem_en_ex=1, mem_rw_ex=1; RW_dm=0 two cycles later.
- Writer of R0 followed by a reader of R0 -> selects 0 and no stall.
- Two writers of R1 back-to-back, then a reader -> mux_sel_A=1.
- HAZARD_STATS_EN build: the load-use sequence above -> stall_cnt=1, fwd_cnt=1.
